// File: rtl/video_timing_pattern_gen.sv
// Parametrised video timing and test-pattern generator for the HDMI transmitter.
// Derives a pixel tick from clock_50, runs h/v raster counters and registers
// sync, data-enable, coordinates and RGB one pixel after the counter state.
module video_timing_pattern_gen #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter logic        HS_POL     = 1'b0,
   parameter logic        VS_POL     = 1'b0,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned CHECK_LOG2 = 4
) (
   input  logic        clock_50,
   input  logic        reset,
   input  logic [1:0]  mode,
   input  logic [23:0] solid_color,
   output logic        pixel_clock,
   output logic        data_enable,
   output logic        horz_sync,
   output logic        vert_sync,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic [11:0] pixel_x,
   output logic [11:0] pixel_y,
   output logic        frame_start
);

   localparam int unsigned CW       = 12;
   localparam int unsigned DW       = $clog2(CLK_DIV);
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_SYNC_S = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_E = H_SYNC_S + H_SYNC;
   localparam int unsigned V_SYNC_S = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_E = V_SYNC_S + V_SYNC;
   localparam int unsigned BAR_W    = H_ACTIVE / 8;

   logic [DW-1:0] r_div;
   logic          r_pclk;
   logic [CW-1:0] r_h;
   logic [CW-1:0] r_v;
   logic [CW-1:0] r_bar_cnt;
   logic [2:0]    r_bar_idx;
   logic [1:0]    r_mode;
   logic [23:0]   r_solid;
   logic          r_de;
   logic          r_hs;
   logic          r_vs;
   logic [23:0]   r_rgb;
   logic [CW-1:0] r_px;
   logic [CW-1:0] r_py;
   logic          r_fs;

   logic [DW-1:0] w_div_next;
   logic          w_tick;
   logic          w_h_wrap;
   logic          w_first;
   logic          w_de;
   logic          w_hs;
   logic          w_vs;
   logic [1:0]    w_mode;
   logic [23:0]   w_solid;
   logic [23:0]   w_rgb;

   assign w_div_next = (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + DW'(1);
   assign w_tick     = (r_div == DW'(CLK_DIV - 1));
   assign w_h_wrap   = (r_h == CW'(H_TOTAL - 1));

   // Raster decode and pattern selection from the pre-increment counters
   always_comb begin
      w_first = (r_h == '0) && (r_v == '0);
      w_de    = (r_h < CW'(H_ACTIVE)) && (r_v < CW'(V_ACTIVE));
      w_hs    = ((r_h >= CW'(H_SYNC_S)) && (r_h < CW'(H_SYNC_E))) ? HS_POL : ~HS_POL;
      w_vs    = ((r_v >= CW'(V_SYNC_S)) && (r_v < CW'(V_SYNC_E))) ? VS_POL : ~VS_POL;
      w_mode  = w_first ? mode : r_mode;
      w_solid = w_first ? solid_color : r_solid;
      w_rgb   = 24'h000000;
      if (w_de) begin
         case (w_mode)
            2'd0: w_rgb = w_solid;
            2'd1: begin
               case (r_bar_idx)
                  3'd0:    w_rgb = 24'hFFFFFF;
                  3'd1:    w_rgb = 24'hFFFF00;
                  3'd2:    w_rgb = 24'h00FFFF;
                  3'd3:    w_rgb = 24'h00FF00;
                  3'd4:    w_rgb = 24'hFF00FF;
                  3'd5:    w_rgb = 24'hFF0000;
                  3'd6:    w_rgb = 24'h0000FF;
                  default: w_rgb = 24'h000000;
               endcase
            end
            2'd2:    w_rgb = (r_h[CHECK_LOG2] ^ r_v[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
            default: w_rgb = {r_h[7:0], r_h[7:0], r_h[7:0]};
         endcase
      end
   end

   // Clock divider: pixel tick and the pixel_clock pin, low for the first half of the period
   always_ff @(posedge clock_50) begin
      if (reset) begin
         r_div  <= '0;
         r_pclk <= 1'b0;
      end else begin
         r_div  <= w_div_next;
         r_pclk <= (w_div_next >= DW'(CLK_DIV / 2));
      end
   end

   // Horizontal and vertical raster counters
   always_ff @(posedge clock_50) begin
      if (reset) begin
         r_h <= '0;
         r_v <= '0;
      end else if (w_tick) begin
         if (w_h_wrap) begin
            r_h <= '0;
            r_v <= (r_v == CW'(V_TOTAL - 1)) ? '0 : r_v + CW'(1);
         end else begin
            r_h <= r_h + CW'(1);
         end
      end
   end

   // Colour-bar index tracks h/BAR_W by counting, saturating at the last bar
   always_ff @(posedge clock_50) begin
      if (reset) begin
         r_bar_cnt <= '0;
         r_bar_idx <= '0;
      end else if (w_tick) begin
         if (w_h_wrap) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
         end else if (r_bar_cnt == CW'(BAR_W - 1)) begin
            r_bar_cnt <= '0;
            if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
         end else begin
            r_bar_cnt <= r_bar_cnt + CW'(1);
         end
      end
   end

   // Pattern controls are held for a whole frame, refreshed at pixel (0,0)
   always_ff @(posedge clock_50) begin
      if (reset) begin
         r_mode  <= '0;
         r_solid <= '0;
      end else if (w_tick && w_first) begin
         r_mode  <= mode;
         r_solid <= solid_color;
      end
   end

   // Output stage: one pixel of latency, all signals aligned
   always_ff @(posedge clock_50) begin
      if (reset) begin
         r_de  <= 1'b0;
         r_hs  <= ~HS_POL;
         r_vs  <= ~VS_POL;
         r_rgb <= '0;
         r_px  <= '0;
         r_py  <= '0;
         r_fs  <= 1'b0;
      end else if (w_tick) begin
         r_de  <= w_de;
         r_hs  <= w_hs;
         r_vs  <= w_vs;
         r_rgb <= w_rgb;
         r_px  <= r_h;
         r_py  <= r_v;
         r_fs  <= w_first;
      end
   end

   assign pixel_clock = r_pclk;
   assign data_enable = r_de;
   assign horz_sync   = r_hs;
   assign vert_sync   = r_vs;
   assign red         = r_rgb[23:16];
   assign green       = r_rgb[15:8];
   assign blue        = r_rgb[7:0];
   assign pixel_x     = r_px;
   assign pixel_y     = r_py;
   assign frame_start = r_fs;

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Self-checking bench for video_timing_pattern_gen using a reduced raster
// (84 x 30 total, 68 x 24 active) so several whole frames fit in the run.
module tb_video_timing_pattern_gen;

   localparam int HA = 68, HFP = 4, HS = 8, HBP = 4;
   localparam int VA = 24, VFP = 2, VS = 2, VBP = 2;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;

   typedef struct {
      int          x;
      int          y;
      logic [23:0] rgb;
      logic        de;
   } exp_t;

   logic        clock_50 = 1'b0;
   logic        reset;
   logic [1:0]  mode;
   logic [23:0] solid_color;
   logic        pixel_clock, data_enable, horz_sync, vert_sync, frame_start;
   logic [7:0]  red, green, blue;
   logic [11:0] pixel_x, pixel_y;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   video_timing_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .CHECK_LOG2(4)
   ) dut (
      .clock_50(clock_50), .reset(reset), .mode(mode), .solid_color(solid_color),
      .pixel_clock(pixel_clock), .data_enable(data_enable), .horz_sync(horz_sync),
      .vert_sync(vert_sync), .red(red), .green(green), .blue(blue),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
   );

   always #5 clock_50 = ~clock_50;

   // Advance to the next new pixel (first negedge where pixel_clock is low)
   task automatic next_pixel();
      int n = 0;
      do begin
         @(negedge clock_50);
         n++;
      end while (pixel_clock !== 1'b0 && n < 8);
   endtask

   task automatic wait_frame(input string tag);
      int n = 0;
      do begin
         next_pixel();
         n++;
      end while (frame_start !== 1'b1 && n < 2 * FRAME + 10);
      n_checks++;
      if (frame_start !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: frame_start not seen, got %b want 1", tag, frame_start);
      end
   endtask

   task automatic wait_xy(input int x, input int y, input string tag);
      int n = 0;
      while (!(int'(pixel_x) == x && int'(pixel_y) == y) && n < 2 * FRAME + 10) begin
         next_pixel();
         n++;
      end
      n_checks++;
      if (!(int'(pixel_x) == x && int'(pixel_y) == y)) begin
         n_fail++;
         $display("FAIL %s: position not reached, got (%0d,%0d) want (%0d,%0d)",
                  tag, pixel_x, pixel_y, x, y);
      end
   endtask

   function automatic logic [23:0] bar_colour(input int x);
      int idx;
      idx = x / (HA / 8);
      if (idx > 7) idx = 7;
      case (idx)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // Drain the scoreboard in raster order, comparing each expected pixel as it appears
   task automatic run_scoreboard(input string tag, input int budget);
      int n = 0;
      exp_t e;
      while (sb.size() > 0 && n < budget) begin
         if (int'(pixel_x) == sb[0].x && int'(pixel_y) == sb[0].y) begin
            e = sb.pop_front();
            n_checks++;
            if ({red, green, blue} !== e.rgb || data_enable !== e.de) begin
               n_fail++;
               $display("FAIL %s (%0d,%0d): got rgb=%06h de=%b want rgb=%06h de=%b",
                        tag, e.x, e.y, {red, green, blue}, data_enable, e.rgb, e.de);
            end
         end else begin
            next_pixel();
            n++;
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s timeout: got %0d pending want 0", tag, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      logic prev;
      int   bad = 0;
      reset = 1'b1; mode = 2'd0; solid_color = 24'h123456;
      repeat (5) @(negedge clock_50);
      n_checks++;
      if ({pixel_clock, horz_sync, vert_sync, data_enable, frame_start} !== 5'b01100 ||
          {red, green, blue} !== 24'h0 || pixel_x !== 12'd0 || pixel_y !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_idle: got pclk=%b hs=%b vs=%b de=%b fs=%b rgb=%06h x=%0d y=%0d want 0 1 1 0 0 000000 0 0",
                  pixel_clock, horz_sync, vert_sync, data_enable, frame_start,
                  {red, green, blue}, pixel_x, pixel_y);
      end
      reset = 1'b0;
      @(negedge clock_50);
      n_checks++;
      if (pixel_clock !== 1'b1 || data_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL release_cycle1: got pclk=%b de=%b want 1 0", pixel_clock, data_enable);
      end
      @(negedge clock_50);
      n_checks++;
      if (data_enable !== 1'b1 || frame_start !== 1'b1 || pixel_x !== 12'd0 ||
          pixel_y !== 12'd0 || {red, green, blue} !== 24'h123456) begin
         n_fail++;
         $display("FAIL first_pixel: got de=%b fs=%b x=%0d y=%0d rgb=%06h want 1 1 0 0 123456",
                  data_enable, frame_start, pixel_x, pixel_y, {red, green, blue});
      end
      prev = pixel_clock;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock_50);
         if (pixel_clock === prev) bad++;
         prev = pixel_clock;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL pclk_toggle: got %0d non-toggling cycles want 0", bad);
      end
   endtask

   task automatic test_line_timing();
      int t_de_fall = -1, t_hs_low = -1, t_hs_high = -1, t_de_rise = -1;
      wait_xy(0, 0, "line_start");
      for (int t = 1; t <= 200 && t_de_rise < 0; t++) begin
         next_pixel();
         if (data_enable === 1'b0 && t_de_fall < 0) t_de_fall = t;
         if (horz_sync === 1'b0 && t_hs_low < 0) t_hs_low = t;
         if (horz_sync === 1'b1 && t_hs_low >= 0 && t_hs_high < 0) t_hs_high = t;
         if (data_enable === 1'b1 && t_de_fall >= 0) t_de_rise = t;
      end
      n_checks++;
      if (t_de_fall != HA) begin
         n_fail++; $display("FAIL de_width: got %0d want %0d", t_de_fall, HA);
      end
      n_checks++;
      if (t_hs_low != HA + HFP) begin
         n_fail++; $display("FAIL hs_start: got %0d want %0d", t_hs_low, HA + HFP);
      end
      n_checks++;
      if (t_hs_high - t_hs_low != HS) begin
         n_fail++; $display("FAIL hs_width: got %0d want %0d", t_hs_high - t_hs_low, HS);
      end
      n_checks++;
      if (t_de_rise != HT) begin
         n_fail++; $display("FAIL line_period: got %0d want %0d", t_de_rise, HT);
      end
   endtask

   task automatic test_frame_timing();
      int t = 0, vs_t0 = -1, vs_t1 = -1, vs_y = -1, vs_x = -1, de_cnt = 0, de_blank = 0;
      wait_frame("frame_sync");
      do begin
         if (data_enable === 1'b1) begin
            de_cnt++;
            if (int'(pixel_y) >= VA) de_blank++;
         end
         if (vert_sync === 1'b0 && vs_t0 < 0) begin
            vs_t0 = t; vs_y = int'(pixel_y); vs_x = int'(pixel_x);
         end
         if (vert_sync === 1'b1 && vs_t0 >= 0 && vs_t1 < 0) vs_t1 = t;
         next_pixel();
         t++;
      end while (frame_start !== 1'b1 && t < FRAME + 100);
      n_checks++;
      if (t != FRAME) begin
         n_fail++; $display("FAIL frame_period: got %0d want %0d", t, FRAME);
      end
      n_checks++;
      if (vs_y != VA + VFP || vs_x != 0) begin
         n_fail++; $display("FAIL vs_start: got (%0d,%0d) want (0,%0d)", vs_x, vs_y, VA + VFP);
      end
      n_checks++;
      if (vs_t1 - vs_t0 != VS * HT) begin
         n_fail++; $display("FAIL vs_width: got %0d want %0d", vs_t1 - vs_t0, VS * HT);
      end
      n_checks++;
      if (de_cnt != HA * VA || de_blank != 0) begin
         n_fail++; $display("FAIL de_count: got %0d/%0d want %0d/0", de_cnt, de_blank, HA * VA);
      end
   endtask

   task automatic test_bars();
      exp_t e;
      mode = 2'd1;
      wait_frame("bars_frame");
      for (int x = 0; x < HT; x++) begin
         e.x = x; e.y = 1;
         e.de  = (x < HA);
         e.rgb = (x < HA) ? bar_colour(x) : 24'h000000;
         sb.push_back(e);
      end
      run_scoreboard("bars", 2 * FRAME);
   endtask

   task automatic test_mode_change();
      exp_t e;
      int   xs[4] = '{0, 33, 67, 70};
      mode = 2'd0; solid_color = 24'h123456;
      wait_frame("solid_frame");
      wait_xy(0, 10, "line10");
      mode = 2'd2;
      for (int y = 10; y < VA; y++) begin
         foreach (xs[i]) begin
            e.x = xs[i]; e.y = y;
            e.de  = (xs[i] < HA);
            e.rgb = (xs[i] < HA) ? 24'h123456 : 24'h000000;
            sb.push_back(e);
         end
      end
      e.de = 1'b1;
      e.x = 0;  e.y = 0;  e.rgb = 24'hFFFFFF; sb.push_back(e);
      e.x = 16; e.y = 0;  e.rgb = 24'h000000; sb.push_back(e);
      e.x = 16; e.y = 16; e.rgb = 24'hFFFFFF; sb.push_back(e);
      e.x = 5;  e.y = 17; e.rgb = 24'h000000; sb.push_back(e);
      run_scoreboard("mode_change", 2 * FRAME);
   endtask

   task automatic test_gradient();
      exp_t e;
      mode = 2'd3;
      wait_frame("grad_frame");
      e.y = 2; e.de = 1'b1;
      e.x = 0;  e.rgb = 24'h000000; sb.push_back(e);
      e.x = 5;  e.rgb = 24'h050505; sb.push_back(e);
      e.x = 67; e.rgb = 24'h434343; sb.push_back(e);
      e.x = 80; e.rgb = 24'h000000; e.de = 1'b0; sb.push_back(e);
      run_scoreboard("gradient", 2 * FRAME);
   endtask

   task automatic test_reset_midframe();
      wait_xy(75, 26, "sync_region");
      n_checks++;
      if (horz_sync !== 1'b0 || vert_sync !== 1'b0) begin
         n_fail++; $display("FAIL pre_reset_sync: got hs=%b vs=%b want 0 0", horz_sync, vert_sync);
      end
      reset = 1'b1;
      @(negedge clock_50);
      n_checks++;
      if ({pixel_clock, horz_sync, vert_sync, data_enable, frame_start} !== 5'b01100 ||
          {red, green, blue} !== 24'h0 || pixel_x !== 12'd0 || pixel_y !== 12'd0) begin
         n_fail++;
         $display("FAIL midframe_idle: got pclk=%b hs=%b vs=%b de=%b fs=%b rgb=%06h x=%0d y=%0d want 0 1 1 0 0 000000 0 0",
                  pixel_clock, horz_sync, vert_sync, data_enable, frame_start,
                  {red, green, blue}, pixel_x, pixel_y);
      end
      repeat (2) @(negedge clock_50);
      reset = 1'b0;
      repeat (2) @(negedge clock_50);
      n_checks++;
      if (frame_start !== 1'b1 || data_enable !== 1'b1 || pixel_x !== 12'd0 || pixel_y !== 12'd0) begin
         n_fail++;
         $display("FAIL restart_pixel: got fs=%b de=%b x=%0d y=%0d want 1 1 0 0",
                  frame_start, data_enable, pixel_x, pixel_y);
      end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_bars();
      test_mode_change();
      test_gradient();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
